boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_pkg.sv | 9 +
 rtl/boot_loader_if.sv | 11 +
 rtl/boot_loader.sv | 94 +++++++++
 tb/tb_boot_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// boot_pkg: loader state encoding and stream-format constants shared by the loader and its users.
package boot_pkg;
  typedef enum logic [2:0] {LEN0, LEN1, LOAD, CHECK, RUN, ERR} boot_state_t;
  localparam int LEN_W = 16;
  localparam logic [1:0] LAST_BYTE = 2'd3;
`ifdef BOOT_CHECKSUM_EN
  localparam logic [7:0] CSUM_SEED = 8'h00;
`endif
endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-stream ingress handshake plus instruction-memory write bundle.
interface boot_loader_if #(parameter int ADDR_W = 8);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  modport master (output rx_valid, rx_data, input rx_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (input rx_valid, rx_data, output rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/boot_loader.sv
// boot_loader: loads a length-prefixed little-endian image into instruction memory, then releases the CPU.
// Optional BOOT_CHECKSUM_EN: a trailing XOR-of-payload byte is checked before release.
module boot_loader
  import boot_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_rstn,
  output logic              o_done,
  output logic              o_err
);
  boot_state_t      r_state, w_next;
  logic             r_live;
  logic [LEN_W-1:0] r_len, r_word, w_n;
  logic [1:0]       r_byte;
  logic [23:0]      r_shift;
  logic             w_rdy, w_fire, w_last;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       r_sum;
`endif
  assign w_n    = {i_rx_data, r_len[7:0]};
  assign w_last = r_byte == LAST_BYTE && r_word == r_len - LEN_W'(1);
  // r_live keeps ready low while reset is held and for the first edge after release
  always_comb begin
`ifdef BOOT_CHECKSUM_EN
    w_rdy = r_live && r_state inside {LEN0, LEN1, LOAD, CHECK};
`else
    w_rdy = r_live && r_state inside {LEN0, LEN1, LOAD};
`endif
    w_fire = i_rx_valid & w_rdy;
    w_next = r_state;
    case (r_state)
      LEN0:  w_next = w_fire ? LEN1 : LEN0;
      LEN1:  w_next = !w_fire ? LEN1 : w_n == '0 ? CHECK : {16'd0, w_n} > MEM_DEPTH ? ERR : LOAD;
      LOAD:  w_next = w_fire && w_last ? CHECK : LOAD;
`ifdef BOOT_CHECKSUM_EN
      CHECK: w_next = !w_fire ? CHECK : i_rx_data == r_sum ? RUN : ERR;
`else
      CHECK: w_next = RUN;
`endif
      default: w_next = r_state;
    endcase
  end
  assign o_rx_ready = w_rdy;
  assign o_done     = r_state == RUN;
  assign o_err      = r_state == ERR;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= LEN0;
      r_live       <= 1'b0;
      r_len        <= '0;
      r_word       <= '0;
      r_byte       <= '0;
      r_shift      <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_cpu_rstn   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_sum        <= CSUM_SEED;
`endif
    end else begin
      r_state    <= w_next;
      r_live     <= 1'b1;
      o_imem_we  <= 1'b0;
      o_cpu_rstn <= o_done;
      if (w_fire && r_state == LEN0) r_len[7:0] <= i_rx_data;
      if (w_fire && r_state == LEN1) r_len[15:8] <= i_rx_data;
      if (w_fire && r_state == LOAD) begin
        r_byte <= r_byte + 2'd1;
`ifdef BOOT_CHECKSUM_EN
        r_sum  <= r_sum ^ i_rx_data;
`endif
        if (r_byte == LAST_BYTE) begin
          o_imem_we    <= 1'b1;
          o_imem_addr  <= r_word[ADDR_W-1:0];
          o_imem_wdata <= {i_rx_data, r_shift};
          r_word       <= r_word + LEN_W'(1);
        end else begin
          r_shift[{r_byte, 3'b000} +: 8] <= i_rx_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: table vectors plus randomized images checked against a stream-parsing reference model.
module tb_boot_loader;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  typedef logic [7:0]     bq_t[$];
  typedef logic [AW+31:0] wq_t[$];
  typedef struct {
    int               len;
    logic [0:11][7:0] b;
    int               gap;
    int               nwr;
    logic [31:0]      w0, w1;
    bit               run_e, err_e;
  } vec_t;

  logic clk = 1'b0, rstn = 1'b1;
  logic cpu_rstn, done, err;
  int   n_vec = 0, n_bad = 0, cyc = 0, done_cyc = -1, rstn_cyc = -1;
  wq_t  wq;
  vec_t tbl[6];

  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_W(AW)) bus ();

  boot_loader #(.MEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_rx_valid(bus.rx_valid), .i_rx_data(bus.rx_data),
    .o_rx_ready(bus.rx_ready), .o_imem_we(bus.imem_we), .o_imem_addr(bus.imem_addr),
    .o_imem_wdata(bus.imem_wdata), .o_cpu_rstn(cpu_rstn), .o_done(done), .o_err(err));

  // write log and release timing, cleared whenever reset is held
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      wq.delete();
      done_cyc = -1;
      rstn_cyc = -1;
    end else begin
      if (bus.imem_we) wq.push_back({bus.imem_addr, bus.imem_wdata});
      if (done && done_cyc < 0) done_cyc = cyc;
      if (cpu_rstn && rstn_cyc < 0) rstn_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: parse the stream by its format rules
  function automatic void model(input bq_t s, output wq_t w, output bit run_e, output bit err_e);
    int n;
    logic [31:0] wd;
    logic [7:0] x;
    w = {};
    x = 8'h00;
    n = int'({s[1], s[0]});
    if (n > DEPTH) begin
      run_e = 1'b0;
      err_e = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      wd = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
      w.push_back({AW'(i), wd});
      x = x ^ wd[7:0] ^ wd[15:8] ^ wd[23:16] ^ wd[31:24];
    end
`ifdef BOOT_CHECKSUM_EN
    run_e = s[2+4*n] == x;
`else
    run_e = 1'b1;
`endif
    err_e = !run_e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL handshake: rx_ready stayed 0 for byte %0h", b);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run(input string tag, input bq_t s, input int gap, input wq_t ew,
                     input bit run_e, input bit err_e, input bit rst);
    if (rst) do_reset();
    foreach (s[i]) send(s[i], gap > 0 ? int'($urandom_range(0, gap)) : 0);
    repeat (4) @(negedge clk);
    chk({tag, " nwr"}, 64'(wq.size()), 64'(ew.size()));
    foreach (ew[i]) if (i < wq.size()) chk($sformatf("%s wr%0d", tag, i), 64'(wq[i]), 64'(ew[i]));
    chk({tag, " done"}, 64'(done), 64'(run_e));
    chk({tag, " err"}, 64'(err), 64'(err_e));
    chk({tag, " cpu_rstn"}, 64'(cpu_rstn), 64'(run_e));
    chk({tag, " rx_ready"}, 64'(bus.rx_ready), 64'(0));
    if (run_e) chk({tag, " rstn_lag"}, 64'(rstn_cyc - done_cyc), 64'(1));
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    repeat (4) @(negedge clk);
    bus.rx_valid = 1'b0;
    chk({tag, " ignore nwr"}, 64'(wq.size()), 64'(ew.size()));
    chk({tag, " ignore done"}, 64'(done), 64'(run_e));
  endtask

  initial begin
    bq_t s;
    wq_t ew;
    bit  re, ee;
    int  n;
    logic [31:0] wd;
    logic [7:0]  x;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
`ifdef BOOT_CHECKSUM_EN
    tbl[0] = '{11, 96'h02_00_13_00_00_00_93_00_10_00_90_00, 0, 2, 32'h00000013, 32'h00100093, 1'b1, 1'b0};
    tbl[1] = '{11, 96'h02_00_13_00_00_00_93_00_10_00_90_00, 5, 2, 32'h00000013, 32'h00100093, 1'b1, 1'b0};
    tbl[2] = '{3,  96'h00_00_00_00_00_00_00_00_00_00_00_00, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[3] = '{2,  96'h01_01_00_00_00_00_00_00_00_00_00_00, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
    tbl[4] = '{7,  96'h01_00_EF_BE_AD_DE_22_00_00_00_00_00, 2, 1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0};
    tbl[5] = '{11, 96'h02_00_13_00_00_00_93_00_10_00_91_00, 0, 2, 32'h00000013, 32'h00100093, 1'b0, 1'b1};
`else
    tbl[0] = '{10, 96'h02_00_13_00_00_00_93_00_10_00_00_00, 0, 2, 32'h00000013, 32'h00100093, 1'b1, 1'b0};
    tbl[1] = '{10, 96'h02_00_13_00_00_00_93_00_10_00_00_00, 5, 2, 32'h00000013, 32'h00100093, 1'b1, 1'b0};
    tbl[2] = '{2,  96'h00_00_00_00_00_00_00_00_00_00_00_00, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[3] = '{2,  96'h01_01_00_00_00_00_00_00_00_00_00_00, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
    tbl[4] = '{6,  96'h01_00_EF_BE_AD_DE_00_00_00_00_00_00, 2, 1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0};
    tbl[5] = '{2,  96'hFF_FF_00_00_00_00_00_00_00_00_00_00, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
`endif
    #1 rstn = 1'b0;
    #1;
    chk("reset rx_ready", 64'(bus.rx_ready), 64'(0));
    chk("reset we", 64'(bus.imem_we), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset err", 64'(err), 64'(0));
    chk("reset cpu_rstn", 64'(cpu_rstn), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int v = 0; v < 6; v++) begin
      s  = {};
      ew = {};
      for (int i = 0; i < tbl[v].len; i++) s.push_back(tbl[v].b[i]);
      if (tbl[v].nwr > 0) ew.push_back({AW'(0), tbl[v].w0});
      if (tbl[v].nwr > 1) ew.push_back({AW'(1), tbl[v].w1});
      run($sformatf("vec%0d", v), s, tbl[v].gap, ew, tbl[v].run_e, tbl[v].err_e, 1'b1);
    end

    // reset after five payload bytes, then a fresh one-word image without another reset
    do_reset();
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
    foreach (s[i]) send(s[i], 0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst rx_ready", 64'(bus.rx_ready), 64'(0));
    chk("midrst we", 64'(bus.imem_we), 64'(0));
    chk("midrst addr", 64'(bus.imem_addr), 64'(0));
    chk("midrst wdata", 64'(bus.imem_wdata), 64'(0));
    chk("midrst cpu_rstn", 64'(cpu_rstn), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef BOOT_CHECKSUM_EN
    s.push_back(8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12);
`endif
    model(s, ew, re, ee);
    run("midrst", s, 0, ew, re, ee, 1'b0);

    // full-depth image: last address must be DEPTH-1 with no wrap
    s = {8'(DEPTH), 8'(DEPTH >> 8)};
    x = 8'h00;
    for (int i = 0; i < DEPTH * 4; i++) begin
      s.push_back(8'($urandom));
      x ^= s[s.size()-1];
    end
`ifdef BOOT_CHECKSUM_EN
    s.push_back(x);
`endif
    model(s, ew, re, ee);
    run("full", s, 0, ew, re, ee, 1'b1);

    for (int r = 0; r < 15; r++) begin
      n = ($urandom_range(0, 7) == 0) ? DEPTH + 1 + int'($urandom_range(0, 300)) : int'($urandom_range(0, 6));
      s = {8'(n), 8'(n >> 8)};
      x = 8'h00;
      if (n <= DEPTH) begin
        for (int i = 0; i < n; i++) begin
          wd = $urandom;
          for (int k = 0; k < 4; k++) s.push_back(wd[8*k +: 8]);
          x ^= wd[7:0] ^ wd[15:8] ^ wd[23:16] ^ wd[31:24];
        end
`ifdef BOOT_CHECKSUM_EN
        s.push_back(x ^ (($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00));
`endif
      end
      model(s, ew, re, ee);
      run($sformatf("rnd%0d", r), s, 3, ew, re, ee, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
